// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers for the multi-cycle MIPS datapath.
// One radix-2 step per cycle; sign handling via operand magnitudes and a final fix-up cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hi_oe,
  input  logic             lo_oe,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  // state  | meaning
  // S_IDLE | waiting for start; MTHI/MTLO writes accepted
  // S_CALC | WIDTH shift-add / shift-subtract steps
  // S_FIX  | sign correction, HI/LO written at end of cycle
  // S_DONE | done pulse; MTHI/MTLO writes accepted
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic                bz_q, bz_d;
  logic [WIDTH-1:0]    araw_q, araw_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic                dz_q, dz_d;

  logic                in_sa, in_sb;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH+1:0]    div_diff;
  logic [2*WIDTH-1:0]  prod_neg;
  logic                is_signed;

  assign in_sa  = ~op[0] & a[WIDTH-1];
  assign in_sb  = ~op[0] & b[WIDTH-1];
  assign a_mag  = in_sa ? -a : a;
  assign b_mag  = in_sb ? -b : b;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  // Partial remainder shifted left needs WIDTH+1 bits; the top bit of the diff is the borrow.
  assign div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
  assign prod_neg = -acc_q;
  assign is_signed = ~op_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      araw_q  <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      araw_q  <= araw_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    araw_d  = araw_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_CALC;
          op_d    = op;
          sa_d    = in_sa;
          sb_d    = in_sb;
          bz_d    = (b == '0);
          araw_d  = a;
          cnt_d   = CW'(WIDTH - 1);
          dz_d    = 1'b0;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end
      end
      S_CALC: begin
        if (op_q[1]) begin
          if (!div_diff[WIDTH+1]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (op_q[1]) begin
          if (bz_q) begin
            lo_d = '1;
            hi_d = araw_q;
            dz_d = 1'b1;
          end else begin
            lo_d = (is_signed & (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = (is_signed & sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end
        end else if (is_signed & (sa_q ^ sb_q)) begin
          {hi_d, lo_d} = prod_neg;
        end else begin
          {hi_d, lo_d} = acc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q == S_CALC) || (state_q == S_FIX);
  assign done  = (state_q == S_DONE);
  assign dz    = dz_q;
  assign rdata = lo_oe ? lo_q : (hi_oe ? hi_q : '0);

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic results, latency, dz, MTHI/MTLO, abort by reset.
module tb_mdu_iter;
  logic        clk, rst, start, hi_we, lo_we, hi_oe, lo_oe;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, rdata;
  logic        busy, done, dz;
  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi_oe(hi_oe), .lo_oe(lo_oe),
    .rdata(rdata), .busy(busy), .done(done), .dz(dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic rd(input logic h, input logic l, output logic [31:0] v);
    hi_oe = h;
    lo_oe = l;
    #1;
    v = rdata;
    hi_oe = 1'b0;
    lo_oe = 1'b0;
  endtask

  // Launch one operation; done_at is the number of edges after the accepting edge at which done is seen.
  task automatic do_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                       input logic hwe, input logic [31:0] wd, input bit inject,
                       output int done_at, output logic [31:0] mid_hi, output logic [31:0] mid_lo,
                       output logic [31:0] res_hi, output logic [31:0] res_lo,
                       output logic busy_first, output logic done_after);
    @(negedge clk);
    start = 1'b1; op = op_v; a = a_v; b = b_v; hi_we = hwe; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    busy_first = busy;
    done_at = -1;
    mid_hi = 'x; mid_lo = 'x;
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      @(posedge clk); #1;
      if (i == 6) begin start = 1'b0; hi_we = 1'b0; end
      if (done) done_at = i;
      if (i == 10) begin
        rd(1'b1, 1'b0, mid_hi);
        rd(1'b0, 1'b1, mid_lo);
      end
      if (i == 5 && inject) begin
        start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd1; hi_we = 1'b1; wdata = 32'h0000DEAD;
      end
    end
    rd(1'b1, 1'b0, res_hi);
    rd(1'b0, 1'b1, res_lo);
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", dz); end
    rd(1'b1, 1'b0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", v); end
    rd(1'b0, 1'b1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", v); end
  endtask

  task automatic test_multu_max;
    int da; logic [31:0] mh, ml, h, l; logic bf, dn;
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, da, mh, ml, h, l, bf, dn);
    checks++; if (bf !== 1'b1) begin errors++; $display("FAIL multu_busy got %b want 1", bf); end
    checks++; if (da != 33) begin errors++; $display("FAIL multu_latency got %0d want 33 edges", da); end
    checks++; if (h !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", h); end
    checks++; if (l !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", l); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", dn); end
  endtask

  task automatic test_mult_divu;
    int da; logic [31:0] mh, ml, h, l; logic bf, dn;
    do_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 32'h0, 1'b0, da, mh, ml, h, l, bf, dn);
    checks++; if (mh !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_busy_hi got %h want fffffffe", mh); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", h); end
    checks++; if (l !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", l); end
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 32'h0, 1'b0, da, mh, ml, h, l, bf, dn);
    checks++; if (ml !== 32'hFFFFFFEB) begin errors++; $display("FAIL divu_busy_lo got %h want ffffffeb", ml); end
    checks++; if (da != 33) begin errors++; $display("FAIL divu_latency got %0d want 33 edges", da); end
    checks++; if (l !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want 0000000e", l); end
    checks++; if (h !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 00000002", h); end
  endtask

  task automatic test_div_signed;
    int da; logic [31:0] mh, ml, h, l; logic bf, dn;
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 32'h0, 1'b0, da, mh, ml, h, l, bf, dn);
    checks++; if (l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", l); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", h); end
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, da, mh, ml, h, l, bf, dn);
    checks++; if (l !== 32'h80000000) begin errors++; $display("FAIL div_wrap_lo got %h want 80000000", l); end
    checks++; if (h !== 32'h0) begin errors++; $display("FAIL div_wrap_hi got %h want 00000000", h); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_wrap_dz got %b want 0", dz); end
  endtask

  task automatic test_div_zero;
    int da; logic [31:0] mh, ml, h, l; logic bf, dn;
    do_op(2'b10, 32'h12345678, 32'h0, 1'b0, 32'h0, 1'b0, da, mh, ml, h, l, bf, dn);
    checks++; if (da != 33) begin errors++; $display("FAIL dz_latency got %0d want 33 edges", da); end
    checks++; if (l !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_lo got %h want ffffffff", l); end
    checks++; if (h !== 32'h12345678) begin errors++; $display("FAIL dz_hi got %h want 12345678", h); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", dz); end
    do_op(2'b01, 32'd2, 32'd3, 1'b0, 32'h0, 1'b0, da, mh, ml, h, l, bf, dn);
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL dz_clear got %b want 0", dz); end
    checks++; if (h !== 32'h0) begin errors++; $display("FAIL dz_next_hi got %h want 0", h); end
    checks++; if (l !== 32'd6) begin errors++; $display("FAIL dz_next_lo got %h want 6", l); end
  endtask

  task automatic test_ignore_and_mt;
    int da; int extra; logic [31:0] mh, ml, h, l, v; logic bf, dn;
    // write with start lands in HI; start/MTHI during CALC are dropped
    do_op(2'b01, 32'd5, 32'd9, 1'b1, 32'h00001111, 1'b1, da, mh, ml, h, l, bf, dn);
    checks++; if (mh !== 32'h00001111) begin errors++; $display("FAIL mt_with_start got %h want 00001111", mh); end
    checks++; if (da != 33) begin errors++; $display("FAIL ignore_latency got %0d want 33 edges", da); end
    checks++; if (h !== 32'h0) begin errors++; $display("FAIL ignore_hi got %h want 0", h); end
    checks++; if (l !== 32'd45) begin errors++; $display("FAIL ignore_lo got %h want 0000002d", l); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL no_queue got %0d active cycles want 0", extra); end
    @(negedge clk); hi_we = 1'b1; wdata = 32'h0000DEAD;
    @(negedge clk); hi_we = 1'b0;
    rd(1'b1, 1'b0, v);
    checks++; if (v !== 32'h0000DEAD) begin errors++; $display("FAIL mthi got %h want 0000dead", v); end
    @(negedge clk); lo_we = 1'b1; wdata = 32'h00001234;
    @(negedge clk); lo_we = 1'b0;
    rd(1'b1, 1'b1, v);
    checks++; if (v !== 32'h00001234) begin errors++; $display("FAIL lo_priority got %h want 00001234", v); end
    rd(1'b0, 1'b0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rdata_gated got %h want 0", v); end
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000BEEF;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    rd(1'b1, 1'b0, v);
    checks++; if (v !== 32'h0000BEEF) begin errors++; $display("FAIL both_we_hi got %h want 0000beef", v); end
    rd(1'b0, 1'b1, v);
    checks++; if (v !== 32'h0000BEEF) begin errors++; $display("FAIL both_we_lo got %h want 0000beef", v); end
  endtask

  task automatic test_reset_abort;
    int da; int seen; logic [31:0] mh, ml, h, l, v; logic bf, dn;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    rd(1'b1, 1'b0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL abort_hi got %h want 0", v); end
    rd(1'b0, 1'b1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL abort_lo got %h want 0", v); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    do_op(2'b00, 32'd3, 32'd4, 1'b0, 32'h0, 1'b0, da, mh, ml, h, l, bf, dn);
    checks++; if (da != 33) begin errors++; $display("FAIL after_abort_latency got %0d want 33 edges", da); end
    checks++; if (l !== 32'd12) begin errors++; $display("FAIL after_abort_lo got %h want 0000000c", l); end
    checks++; if (h !== 32'h0) begin errors++; $display("FAIL after_abort_hi got %h want 0", h); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; hi_oe = 1'b0; lo_oe = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    test_reset;
    test_multu_max;
    test_mult_divu;
    test_div_signed;
    test_div_zero;
    test_ignore_and_mt;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
